if_id_skid_stage: RTL

- Parametrised IF/ID pipeline stage: replaces the plain enable/clear register with a two-entry skid buffer and a valid/ready handshake on both sides.
- Sits between fetch and decode. Carries instruction, PC and PC+4.
- Stall is expressed as back-pressure. Flush inserts a canonical NOP bubble.
- up_ready comes straight from a flop, so no combinational path exists from the decode-side ready to fetch.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/if_id_skid_stage.sv | 119 +++++++++++
 2 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage types and constants.
// Payload bundles used by the skid-buffered stage registers.
package pipe_pkg;

    localparam int unsigned PIPE_XLEN = 32;

    // addi x0, x0, 0
    localparam logic [PIPE_XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [PIPE_XLEN-1:0] instr;
        logic [PIPE_XLEN-1:0] pc;
        logic [PIPE_XLEN-1:0] pc_plus_4;
    } if_id_payload_t;

endpackage

// File: rtl/if_id_skid_stage.sv
// IF/ID stage register as a two-entry skid buffer with valid/ready on both sides.
// Ports: clk, rst (async, active high), flush, up_valid/up_ready + InstrF/PCF/PC_plus_4F
// from fetch, dn_valid/dn_ready + InstrD/PCD/PC_plus_4D to decode, occupancy (0..2).
module if_id_skid_stage
    import pipe_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH = PIPE_XLEN,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = pipe_pkg::NOP_INSTR,
    parameter logic [DATA_WIDTH-1:0] RESET_PC  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  up_valid,
    output logic                  up_ready,
    input  logic [DATA_WIDTH-1:0] InstrF,
    input  logic [DATA_WIDTH-1:0] PCF,
    input  logic [DATA_WIDTH-1:0] PC_plus_4F,
    output logic                  dn_valid,
    input  logic                  dn_ready,
    output logic [DATA_WIDTH-1:0] InstrD,
    output logic [DATA_WIDTH-1:0] PCD,
    output logic [DATA_WIDTH-1:0] PC_plus_4D,
    output logic [1:0]            occupancy
);

    logic           m_valid;
    logic           s_valid;
    if_id_payload_t m_payload;
    if_id_payload_t s_payload;
    logic           up_ready_q;

    logic           m_valid_n;
    logic           s_valid_n;
    if_id_payload_t m_payload_n;
    if_id_payload_t s_payload_n;
    if_id_payload_t in_payload;

    logic accept;
    logic consume;

    assign in_payload = '{instr: InstrF, pc: PCF, pc_plus_4: PC_plus_4F};

    assign accept  = up_valid & up_ready_q;
    assign consume = m_valid & dn_ready;

    always_comb begin
        m_valid_n   = m_valid;
        s_valid_n   = s_valid;
        m_payload_n = m_payload;
        s_payload_n = s_payload;
        if (flush) begin
            m_valid_n = 1'b0;
            s_valid_n = 1'b0;
        end else if (!m_valid) begin
            if (accept) begin
                m_valid_n   = 1'b1;
                m_payload_n = in_payload;
            end
        end else if (consume) begin
            if (s_valid) begin
                // Skid is older than any new beat, so it drains first.
                m_payload_n = s_payload;
                s_valid_n   = accept;
                if (accept) begin
                    s_payload_n = in_payload;
                end
            end else begin
                m_valid_n = accept;
                if (accept) begin
                    m_payload_n = in_payload;
                end
            end
        end else if (accept) begin
            s_valid_n   = 1'b1;
            s_payload_n = in_payload;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid    <= 1'b0;
            s_valid    <= 1'b0;
            m_payload  <= '0;
            s_payload  <= '0;
            up_ready_q <= 1'b1;
        end else begin
            m_valid    <= m_valid_n;
            s_valid    <= s_valid_n;
            m_payload  <= m_payload_n;
            s_payload  <= s_payload_n;
            // Registered so decode-side ready never reaches fetch combinationally.
            up_ready_q <= !s_valid_n;
        end
    end

    assign up_ready   = up_ready_q;
    assign dn_valid   = m_valid;
    assign InstrD     = m_valid ? m_payload.instr     : NOP_INSTR;
    assign PCD        = m_valid ? m_payload.pc        : RESET_PC;
    assign PC_plus_4D = m_valid ? m_payload.pc_plus_4 : RESET_PC;
    assign occupancy  = {1'b0, m_valid} + {1'b0, s_valid};

    a_no_accept_when_full: assert property (
        @(posedge clk) disable iff (rst)
        !(up_valid && up_ready && m_valid && s_valid)
    );

    a_stable_when_stalled: assert property (
        @(posedge clk) disable iff (rst)
        (m_valid && !dn_ready && !flush) |=> (m_valid && $stable(m_payload))
    );

    a_occupancy_range: assert property (
        @(posedge clk) disable iff (rst)
        occupancy != 2'd3
    );

endmodule
